// File: rtl/dcache_responder_pkg.sv
// Shared request encoding, responder FSM states and address-split helpers for the data cache.
package CACHE;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    FLUSH = 2'd3
  } req_type;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_WB,
    S_FILL,
    S_FILL_WAIT,
    S_RESP
  } dc_state_t;

  localparam int DC_LINE_BYTES = 8;
  localparam int DC_OFF_W      = $clog2(DC_LINE_BYTES);

  function automatic logic [63:0] dc_index(input logic [63:0] addr, input int idx_w);
    return (addr >> DC_OFF_W) & ((64'd1 << idx_w) - 64'd1);
  endfunction

  function automatic logic [63:0] dc_tag(input logic [63:0] addr, input int idx_w);
    return addr >> (DC_OFF_W + idx_w);
  endfunction

endpackage

// File: rtl/dcache_store.sv
// Direct-mapped line storage: tag/data arrays plus async-cleared valid/dirty bits.
// One combinational read port and one synchronous write port that updates a whole entry.
module dcache_store #(
  parameter int SETS   = 64,
  parameter int IDX    = $clog2(SETS),
  parameter int TAG_W  = 58,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [IDX-1:0]    rd_idx,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_dirty,
  input  logic              wr_en,
  input  logic [IDX-1:0]    wr_idx,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  input  logic              wr_dirty
);

  logic [TAG_W-1:0]  tag_mem  [SETS];
  logic [DATA_W-1:0] data_mem [SETS];
  logic [SETS-1:0]   valid_bits;
  logic [SETS-1:0]   dirty_bits;

  assign rd_tag   = tag_mem[rd_idx];
  assign rd_data  = data_mem[rd_idx];
  assign rd_valid = valid_bits[rd_idx];
  assign rd_dirty = dirty_bits[rd_idx];

  // Tag/data contents are meaningless until valid is set, so they carry no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_bits <= '0;
      dirty_bits <= '0;
    end else if (wr_en) begin
      valid_bits[wr_idx] <= wr_valid;
      dirty_bits[wr_idx] <= wr_dirty;
    end
  end

endmodule

// File: rtl/dcache_responder.sv
// Memory-stage cache responder: direct-mapped, write-back, write-allocate 64-bit-line cache.
// Define DCACHE_STATS_EN to add hit/miss/write-back counters as extra outputs.
module dcache_responder
  import CACHE::*;
#(
  parameter int SETS   = 64,
  parameter int ADDR_W = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  CACHE::req_type      cache_req_type,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [63:0]         req_data,
  output logic                mem_respcyc,
  output logic [63:0]         resp_data,
  output logic                mem_req_valid,
  output logic                mem_req_write,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic [63:0]         mem_req_data,
  input  logic                mem_req_ready,
  input  logic                mem_resp_valid,
  input  logic [63:0]         mem_resp_data
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]         stat_hits,
  output logic [31:0]         stat_misses,
  output logic [31:0]         stat_writebacks
`endif
);

  localparam int IDX   = $clog2(SETS);
  localparam int TAG_W = ADDR_W - DC_OFF_W - IDX;

  dc_state_t          state;
  req_type            typ_r;
  logic [ADDR_W-1:0]  addr_r;
  logic [63:0]        data_r;

  logic [IDX-1:0]     idx;
  logic [TAG_W-1:0]   tag;
  logic [TAG_W-1:0]   rd_tag;
  logic [63:0]        rd_data;
  logic               rd_valid;
  logic               rd_dirty;
  logic               hit;
  logic [ADDR_W-1:0]  fill_addr;
  logic [ADDR_W-1:0]  victim_addr;

  logic               wr_en;
  logic               wr_valid;
  logic               wr_dirty;
  logic [63:0]        wr_data;

  assign idx         = IDX'(dc_index(64'(addr_r), IDX));
  assign tag         = TAG_W'(dc_tag(64'(addr_r), IDX));
  assign hit         = rd_valid && (rd_tag == tag);
  assign fill_addr   = {tag, idx, {DC_OFF_W{1'b0}}};
  assign victim_addr = {rd_tag, idx, {DC_OFF_W{1'b0}}};

  dcache_store #(
    .SETS   (SETS),
    .IDX    (IDX),
    .TAG_W  (TAG_W),
    .DATA_W (64)
  ) u_store (
    .clk      (clk),
    .reset    (reset),
    .rd_idx   (idx),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .rd_dirty (rd_dirty),
    .wr_en    (wr_en),
    .wr_idx   (idx),
    .wr_tag   (tag),
    .wr_data  (wr_data),
    .wr_valid (wr_valid),
    .wr_dirty (wr_dirty)
  );

  // Request capture: the latched copy is authoritative for the whole transaction.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && cache_req_type != IDLE) begin
      typ_r  <= cache_req_type;
      addr_r <= req_addr;
      data_r <= req_data;
    end
  end

  // Store update: write hits, allocations, fills and invalidations all target the request's line.
  always_comb begin
    wr_en    = 1'b0;
    wr_valid = 1'b1;
    wr_dirty = 1'b1;
    wr_data  = data_r;
    case (state)
      S_LOOKUP: begin
        if (typ_r == FLUSH) begin
          if (!(hit && rd_dirty)) begin
            wr_en    = 1'b1;
            wr_valid = 1'b0;
            wr_dirty = 1'b0;
          end
        end else if (typ_r == WRITE) begin
          wr_en = hit || !(rd_valid && rd_dirty);
        end
      end
      S_WB: begin
        if (mem_req_ready) begin
          if (typ_r == FLUSH) begin
            wr_en    = 1'b1;
            wr_valid = 1'b0;
            wr_dirty = 1'b0;
          end else if (typ_r == WRITE) begin
            wr_en = 1'b1;
          end
        end
      end
      S_FILL_WAIT: begin
        if (mem_resp_valid) begin
          wr_en    = 1'b1;
          wr_dirty = 1'b0;
          wr_data  = mem_resp_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      mem_respcyc   <= 1'b0;
      resp_data     <= '0;
      mem_req_valid <= 1'b0;
      mem_req_write <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_data  <= '0;
    end else begin
      mem_respcyc <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cache_req_type != IDLE) state <= S_LOOKUP;
        end
        S_LOOKUP: begin
          if (typ_r == FLUSH ? (hit && rd_dirty) : (!hit && rd_valid && rd_dirty)) begin
            mem_req_valid <= 1'b1;
            mem_req_write <= 1'b1;
            mem_req_addr  <= victim_addr;
            mem_req_data  <= rd_data;
            state         <= S_WB;
          end else if (typ_r == READ && !hit) begin
            mem_req_valid <= 1'b1;
            mem_req_write <= 1'b0;
            mem_req_addr  <= fill_addr;
            state         <= S_FILL;
          end else begin
            mem_respcyc <= 1'b1;
            resp_data   <= (typ_r == READ) ? rd_data : 64'd0;
            state       <= S_RESP;
          end
        end
        S_WB: begin
          if (mem_req_ready) begin
            mem_req_write <= 1'b0;
            if (typ_r == READ) begin
              mem_req_addr <= fill_addr;
              state        <= S_FILL;
            end else begin
              mem_req_valid <= 1'b0;
              mem_respcyc   <= 1'b1;
              resp_data     <= 64'd0;
              state         <= S_RESP;
            end
          end
        end
        S_FILL: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= S_FILL_WAIT;
          end
        end
        S_FILL_WAIT: begin
          if (mem_resp_valid) begin
            mem_respcyc <= 1'b1;
            resp_data   <= mem_resp_data;
            state       <= S_RESP;
          end
        end
        S_RESP: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef DCACHE_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_hits       <= '0;
      stat_misses     <= '0;
      stat_writebacks <= '0;
    end else begin
      if (state == S_LOOKUP && (typ_r == READ || typ_r == WRITE)) begin
        if (hit) stat_hits   <= stat_hits + 32'd1;
        else     stat_misses <= stat_misses + 32'd1;
      end
      if (state == S_WB && mem_req_ready) stat_writebacks <= stat_writebacks + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_responder.sv
// Bench for dcache_responder: directed table, back-to-back/stall and reset sequences, random traffic vs. model.
module tb_dcache_responder;
  import CACHE::*;

  localparam int SETS = 64;
  localparam int IDX  = 6;

  logic        clk = 1'b0;
  logic        reset;
  req_type     cache_req_type;
  logic [63:0] req_addr;
  logic [63:0] req_data;
  logic        mem_respcyc;
  logic [63:0] resp_data;
  logic        mem_req_valid;
  logic        mem_req_write;
  logic [63:0] mem_req_addr;
  logic [63:0] mem_req_data;
  logic        mem_req_ready;
  logic        mem_resp_valid;
  logic [63:0] mem_resp_data;

  always #5 clk = ~clk;

  dcache_responder #(.SETS(SETS), .ADDR_W(64)) dut (
    .clk            (clk),
    .reset          (reset),
    .cache_req_type (cache_req_type),
    .req_addr       (req_addr),
    .req_data       (req_data),
    .mem_respcyc    (mem_respcyc),
    .resp_data      (resp_data),
    .mem_req_valid  (mem_req_valid),
    .mem_req_write  (mem_req_write),
    .mem_req_addr   (mem_req_addr),
    .mem_req_data   (mem_req_data),
    .mem_req_ready  (mem_req_ready),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data)
  );

  typedef struct {
    logic        wr;
    logic [63:0] addr;
    logic [63:0] data;
  } txn_t;

  typedef struct {
    req_type     typ;
    logic [63:0] addr;
    logic [63:0] data;
    int          n_mem;
    logic [63:0] resp;
  } vec_t;

  txn_t        obs_q[$];
  txn_t        exp_q[$];
  logic [63:0] env_mem [logic [63:0]];
  logic [63:0] ref_mem [logic [63:0]];

  bit          m_valid [SETS];
  bit          m_dirty [SETS];
  logic [63:0] m_tag   [SETS];
  logic [63:0] m_data  [SETS];

  int checks    = 0;
  int errors    = 0;
  int resp_cnt  = 0;
  int req_cnt   = 0;
  int rdy_delay = 0;
  int mem_lat   = 0;

  function automatic logic [63:0] dflt(input logic [63:0] a);
    return {a[31:0] ^ 32'hDEADBEEF, ~a[31:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Backing memory: programmable ready stall and read latency, logs every accepted request.
  initial begin
    txn_t        cap;
    int          wait_cnt;
    bit          pend;
    int          lat_cnt;
    logic [63:0] pend_addr;
    wait_cnt = 0;
    pend = 0;
    lat_cnt = 0;
    pend_addr = '0;
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data = '0;
    forever begin
      @(negedge clk);
      mem_resp_valid = 1'b0;
      if (pend) begin
        if (lat_cnt == 0) begin
          mem_resp_valid = 1'b1;
          mem_resp_data = env_mem.exists(pend_addr) ? env_mem[pend_addr] : dflt(pend_addr);
          pend = 0;
        end else lat_cnt--;
      end
      if (mem_req_valid) begin
        if (wait_cnt == 0) begin
          cap.wr = mem_req_write;
          cap.addr = mem_req_addr;
          cap.data = mem_req_data;
        end else begin
          check("req_stable_write", 64'(mem_req_write), 64'(cap.wr));
          check("req_stable_addr", mem_req_addr, cap.addr);
          check("req_stable_data", mem_req_data, cap.data);
        end
        if (wait_cnt >= rdy_delay) begin
          mem_req_ready = 1'b1;
          obs_q.push_back(cap);
          if (cap.wr) env_mem[cap.addr] = cap.data;
          else begin
            pend = 1;
            lat_cnt = mem_lat;
            pend_addr = cap.addr;
          end
          wait_cnt = 0;
        end else begin
          mem_req_ready = 1'b0;
          wait_cnt++;
        end
      end else begin
        mem_req_ready = 1'b0;
        wait_cnt = 0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (mem_respcyc) resp_cnt++;
    end
  end

  // Reference: cache as arrays of lines, expected memory traffic derived from write-back/allocate rules.
  task automatic model_req(input req_type t, input logic [63:0] a, input logic [63:0] d,
                           output logic [63:0] resp);
    int          i;
    logic [63:0] tg;
    logic [63:0] la;
    logic [63:0] vaddr;
    bit          hit;
    la = a & ~64'h7;
    i = int'((a >> 3) % SETS);
    tg = a >> (3 + IDX);
    hit = m_valid[i] && (m_tag[i] == tg);
    vaddr = (m_tag[i] << (3 + IDX)) | (64'(i) << 3);
    exp_q.delete();
    if (t == FLUSH) begin
      if (hit && m_dirty[i]) begin
        exp_q.push_back('{1'b1, vaddr, m_data[i]});
        ref_mem[vaddr] = m_data[i];
      end
      m_valid[i] = 0;
      m_dirty[i] = 0;
    end else if (!hit) begin
      if (m_valid[i] && m_dirty[i]) begin
        exp_q.push_back('{1'b1, vaddr, m_data[i]});
        ref_mem[vaddr] = m_data[i];
      end
      if (t == READ) begin
        m_data[i] = ref_mem.exists(la) ? ref_mem[la] : dflt(la);
        m_dirty[i] = 0;
        exp_q.push_back('{1'b0, la, 64'd0});
      end else begin
        m_data[i] = d;
        m_dirty[i] = 1;
      end
      m_valid[i] = 1;
      m_tag[i] = tg;
    end else if (t == WRITE) begin
      m_data[i] = d;
      m_dirty[i] = 1;
    end
    resp = (t == READ) ? m_data[i] : 64'd0;
  endtask

  task automatic do_req(input req_type t, input logic [63:0] a, input logic [63:0] d,
                        output logic [63:0] got, output int nmem);
    logic [63:0] exp_resp;
    int          lat;
    bit          done;
    lat = 0;
    done = 0;
    got = '0;
    model_req(t, a, d, exp_resp);
    @(posedge clk);
    #1;
    obs_q.delete();
    cache_req_type = t;
    req_addr = a;
    req_data = d;
    req_cnt++;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      if (mem_respcyc) begin
        done = 1;
        lat = c;
        got = resp_data;
        break;
      end
    end
    nmem = obs_q.size();
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL respcyc_timeout actual=none required=pulse addr=%h", a);
    end else begin
      check("resp_data", got, exp_resp);
      check("mem_txn_count", 64'(nmem), 64'(exp_q.size()));
      for (int k = 0; k < exp_q.size() && k < nmem; k++) begin
        check("txn_write", 64'(obs_q[k].wr), 64'(exp_q[k].wr));
        check("txn_addr", obs_q[k].addr, exp_q[k].addr);
        if (exp_q[k].wr) check("txn_data", obs_q[k].data, exp_q[k].data);
      end
      if (exp_q.size() == 0) check("no_mem_latency", 64'(lat), 64'd3);
    end
  endtask

  vec_t        vecs[8];
  logic [63:0] got;
  int          nmem;
  int          rc0;
  bit          seen;

  initial begin
    vecs[0] = '{READ,  64'h1000, 64'h0,  1, 64'h1122334455667788};
    vecs[1] = '{READ,  64'h1000, 64'h0,  0, 64'h1122334455667788};
    vecs[2] = '{WRITE, 64'h2000, 64'hAA, 0, 64'h0};
    vecs[3] = '{READ,  64'h2000, 64'h0,  0, 64'hAA};
    vecs[4] = '{READ,  64'h2200, 64'h0,  2, dflt(64'h2200)};
    vecs[5] = '{WRITE, 64'h2000, 64'hAA, 0, 64'h0};
    vecs[6] = '{FLUSH, 64'h2000, 64'h0,  1, 64'h0};
    vecs[7] = '{READ,  64'h2000, 64'h0,  1, 64'hAA};

    env_mem[64'h1000] = 64'h1122334455667788;
    ref_mem[64'h1000] = 64'h1122334455667788;

    reset = 1'b1;
    cache_req_type = IDLE;
    req_addr = '0;
    req_data = '0;
    repeat (3) @(negedge clk);
    check("rst_respcyc", 64'(mem_respcyc), 64'd0);
    check("rst_resp_data", resp_data, 64'd0);
    check("rst_req_valid", 64'(mem_req_valid), 64'd0);
    check("rst_req_write", 64'(mem_req_write), 64'd0);
    check("rst_req_addr", mem_req_addr, 64'd0);
    check("rst_req_data", mem_req_data, 64'd0);
    reset = 1'b0;

    for (int v = 0; v < 8; v++) begin
      do_req(vecs[v].typ, vecs[v].addr, vecs[v].data, got, nmem);
      check("vec_resp", got, vecs[v].resp);
      check("vec_mem_count", 64'(nmem), 64'(vecs[v].n_mem));
    end

    // Back-to-back requests against a slow memory port.
    rdy_delay = 5;
    mem_lat = 2;
    do_req(READ,  64'h3008, 64'h0, got, nmem);
    check("stall_fill_count", 64'(nmem), 64'd1);
    do_req(WRITE, 64'h3008, 64'h5555AAAA12345678, got, nmem);
    do_req(READ,  64'h5008, 64'h0, got, nmem);
    check("stall_wb_fill_count", 64'(nmem), 64'd2);
    do_req(FLUSH, 64'h5008, 64'h0, got, nmem);
    check("stall_clean_flush_count", 64'(nmem), 64'd0);
    do_req(READ,  64'h3008, 64'h0, got, nmem);
    check("stall_readback", got, 64'h5555AAAA12345678);
    rdy_delay = 0;

    // Reset while the fill response is outstanding.
    mem_lat = 20;
    @(posedge clk);
    #1;
    obs_q.delete();
    cache_req_type = READ;
    req_addr = 64'h1000;
    seen = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (obs_q.size() != 0) begin
        seen = 1;
        break;
      end
    end
    check("rstfill_handshake_seen", 64'(seen), 64'd1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    cache_req_type = IDLE;
    rc0 = resp_cnt;
    @(negedge clk);
    check("midrst_respcyc", 64'(mem_respcyc), 64'd0);
    check("midrst_req_valid", 64'(mem_req_valid), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < SETS; i++) begin
      m_valid[i] = 0;
      m_dirty[i] = 0;
    end
    repeat (40) @(negedge clk);
    check("no_resp_after_reset", 64'(resp_cnt), 64'(rc0));
    mem_lat = 0;
    do_req(READ, 64'h1000, 64'h0, got, nmem);
    check("post_reset_miss_count", 64'(nmem), 64'd1);
    check("post_reset_data", got, 64'h1122334455667788);

    // Random traffic over a small address pool to mix hits, conflicts and write-backs.
    for (int n = 0; n < 250; n++) begin
      req_type     t;
      logic [63:0] a;
      rdy_delay = $urandom_range(0, 3);
      mem_lat = $urandom_range(0, 3);
      t = req_type'($urandom_range(1, 3));
      a = (64'($urandom_range(0, 3)) << 9) | (64'($urandom_range(0, 3)) << 3) | 64'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) a[40] = 1'b1;
      do_req(t, a, {$urandom, $urandom}, got, nmem);
    end

    @(posedge clk);
    #1;
    cache_req_type = IDLE;
    repeat (5) @(negedge clk);
    check("respcyc_per_request", 64'(resp_cnt), 64'(req_cnt));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dcache_responder.md
Name: dcache_responder

Overview:
- Responder end of the memory-stage cache request interface.
- Accepts READ/WRITE/FLUSH requests carrying a 64-bit address and 64-bit little-endian byte data.
- Returns a one-cycle `mem_respcyc` pulse with `resp_data`.
- Internally a direct-mapped, write-back, write-allocate data cache of 64-bit lines, backed by a simple request/ready memory port.

Parameters:
- SETS, 64, number of lines; power of 2, ≥2; IDX = log2(SETS).
- ADDR_W, 64, request address width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- cache_req_type  in  CACHE::req_type  IDLE/READ/WRITE/FLUSH; held stable by requester until mem_respcyc
- req_addr  in  64  byte address; bits [2:0] ignored
- req_data  in  64  store data (little-endian bytes), valid for WRITE
- mem_respcyc  out  1  one-cycle completion pulse
- resp_data  out  64  load data, valid when mem_respcyc=1
- mem_req_valid  out  1  backing-memory request
- mem_req_write  out  1  1=write, 0=read
- mem_req_addr  out  64  8-byte-aligned line address
- mem_req_data  out  64  write-back data
- mem_req_ready  in  1  request accepted this cycle
- mem_resp_valid  in  1  read data return
- mem_resp_data  in  64  read data

Behaviour:
- Reset (async): state=S_IDLE; all valid and dirty bits cleared; outputs mem_respcyc=0, resp_data=0, mem_req_valid=0, mem_req_write=0, mem_req_addr=0, mem_req_data=0. Tag/data arrays are not reset.
- Address split: index = addr[3+IDX-1:3]; tag = addr[63:3+IDX].
- S_IDLE: when cache_req_type≠IDLE, latch type/addr/data → S_LOOKUP.
- S_LOOKUP: hit = valid[idx] && tag match.
  - READ hit → resp_data_r = data[idx] → S_RESP.
  - WRITE hit → data[idx] = req_data, dirty=1 → S_RESP.
  - FLUSH hit, line dirty → S_WB. FLUSH hit, clean, or FLUSH miss → invalidate (valid=0, dirty=0) → S_RESP.
  - READ/WRITE miss, victim valid&dirty → S_WB. Otherwise READ → S_FILL, WRITE → install (tag, data, valid=1, dirty=1) → S_RESP.
- S_WB: mem_req_valid=1, write=1, addr={victim_tag, idx, 3'b0}, data=victim data. Held stable until mem_req_ready.
  - On handshake: FLUSH → invalidate → S_RESP; READ → S_FILL; WRITE → install dirty → S_RESP.
- S_FILL: mem_req_valid=1, write=0, addr={tag, idx, 3'b0} until mem_req_ready → S_FILL_WAIT.
- S_FILL_WAIT: on mem_resp_valid, install (valid=1, dirty=0), resp_data_r = mem_resp_data → S_RESP.
- S_RESP: mem_respcyc=1 for exactly one cycle; resp_data = resp_data_r for READ, 0 for WRITE/FLUSH → S_IDLE.
  - The requester may present a new request the very next cycle. S_IDLE treats it as new; the completed request is never re-accepted.
- Latency:
  - hit or clean-miss WRITE/FLUSH: respcyc on the 3rd cycle after request first visible (IDLE→LOOKUP→RESP).
  - miss: adds WB/FILL handshake and memory latency.
- mem_resp_valid outside S_FILL_WAIT is ignored.
- mem_req_ready=1 in the same cycle mem_req_valid rises is a valid handshake.
- cache_req_type changing before respcyc is a protocol violation; the latched copy is used.
- Reset mid-miss: request abandoned, no respcyc issued, in-flight memory response ignored.
- No byte masks: WRITE always writes a full 64-bit line.

Optional Feature:
- DCACHE_STATS_EN defined: adds outputs stat_hits[31:0], stat_misses[31:0], stat_writebacks[31:0].
  - hits/misses increment in S_LOOKUP for READ/WRITE only.
  - writebacks increment on each S_WB handshake.
  - Counters wrap at 2^32 and are cleared by reset.
- Not defined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- CACHE package (existing) keeps req_type. Add:
  - dc_state_t enum (S_IDLE, S_LOOKUP, S_WB, S_FILL, S_FILL_WAIT, S_RESP)
  - DC_LINE_BYTES=8
  - function dc_index/dc_tag
- Sub-module dcache_store: tag/data arrays plus async-reset valid/dirty bit vectors, one read port, one write port. The FSM lives in dcache_responder.

Test Plan:
- Reset, then READ 0x1000, mem returns 0x1122334455667788 → one FILL read at 0x1000, one respcyc with that data; repeat READ 0x1000 → respcyc 2 cycles after IDLE sample, no mem request.
- WRITE 0x2000 data 0xAA (SETS=64) then READ 0x2000 → no memory traffic, resp_data=0xAA; WRITE respcyc has resp_data=0.
- WRITE 0x2000=0xAA, then READ 0x2200 (same index, different tag) → mem write addr 0x2000 data 0xAA, then mem read 0x2200, response data returned.
- FLUSH 0x2000 on dirty line → one write-back of 0xAA; subsequent READ 0x2000 misses and fills.
- Back-to-back requests with respcyc→next request in the following cycle, mem_req_ready held low 5 cycles → exactly one respcyc per request, mem_req_* stable while not ready.
- Assert reset during S_FILL_WAIT, then inject mem_resp_valid → no respcyc, all lines invalid (READ 0x1000 misses).
